morse_keyer: RTL and testbench

//  Parametrised successor to the combinational Morse encoder. Accepts one symbol per

---
 rtl/morse_keyer_if.sv | 8 +
 rtl/morse_keyer.sv | 119 +++++++++++
 tb/tb_morse_keyer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/morse_keyer_if.sv
// morse_keyer_if: symbol valid/ready handshake between a text source and the keyer
interface morse_keyer_if;
  logic       sym_valid;
  logic       sym_ready;
  logic [5:0] sym_code;
  modport master (output sym_valid, sym_code, input sym_ready);
  modport slave (input sym_valid, sym_code, output sym_ready);
endinterface

// File: rtl/morse_keyer.sv
// morse_keyer: accepts one symbol per handshake and keys it out as timed Morse marks/spaces
module morse_keyer #(
  parameter int UNIT_CYCLES    = 4,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7
) (
  input  logic          clk,
  input  logic          rst,
  morse_keyer_if.slave  sym,
  output logic          o_key_out,
  output logic          o_elem_is_dash,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  localparam int MAX_UNITS = (DASH_UNITS > CHAR_GAP_UNITS) ?
    ((DASH_UNITS > WORD_GAP_UNITS) ? DASH_UNITS : WORD_GAP_UNITS) :
    ((CHAR_GAP_UNITS > WORD_GAP_UNITS) ? CHAR_GAP_UNITS : WORD_GAP_UNITS);
  localparam int CW = $clog2(MAX_UNITS * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] L_DOT  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] L_DASH = CW'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] L_CGAP = CW'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] L_WGAP = CW'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MARK, ESPACE, CGAP, WGAP} state_t;

  // Returns {length[2:0], pattern[4:0]}; pattern is left-aligned, bit 4 first, 1 = dash
  function automatic logic [7:0] rom(input logic [5:0] c);
    case (c)
      6'd1:  rom = {3'd2, 5'b01000};
      6'd2:  rom = {3'd4, 5'b10000};
      6'd3:  rom = {3'd4, 5'b10100};
      6'd4:  rom = {3'd3, 5'b10000};
      6'd5:  rom = {3'd1, 5'b00000};
      6'd6:  rom = {3'd4, 5'b00100};
      6'd7:  rom = {3'd3, 5'b11000};
      6'd8:  rom = {3'd4, 5'b00000};
      6'd9:  rom = {3'd2, 5'b00000};
      6'd10: rom = {3'd4, 5'b01110};
      6'd11: rom = {3'd3, 5'b10100};
      6'd12: rom = {3'd4, 5'b01000};
      6'd13: rom = {3'd2, 5'b11000};
      6'd14: rom = {3'd2, 5'b10000};
      6'd15: rom = {3'd3, 5'b11100};
      6'd16: rom = {3'd4, 5'b01100};
      6'd17: rom = {3'd4, 5'b11010};
      6'd18: rom = {3'd3, 5'b01000};
      6'd19: rom = {3'd3, 5'b00000};
      6'd20: rom = {3'd1, 5'b10000};
      6'd21: rom = {3'd3, 5'b00100};
      6'd22: rom = {3'd4, 5'b00010};
      6'd23: rom = {3'd3, 5'b01100};
      6'd24: rom = {3'd4, 5'b10010};
      6'd25: rom = {3'd4, 5'b10110};
      6'd26: rom = {3'd4, 5'b11000};
      6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32:
        rom = {3'd5, 5'b11111 >> (c - 6'd27)};
      6'd33, 6'd34, 6'd35, 6'd36:
        rom = {3'd5, ~(5'b11111 >> (c - 6'd32))};
      default: rom = 8'd0;
    endcase
  endfunction

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_load;
  logic [4:0]    r_pat;
  logic [2:0]    r_len;
  logic          r_done, r_err;
  logic [7:0]    w_rom;
  logic          w_xfer, w_legal, w_zero, w_dash_nx;

  assign w_rom     = rom(sym.sym_code);
  assign w_xfer    = sym.sym_valid & sym.sym_ready;
  assign w_legal   = sym.sym_code <= 6'd36;
  assign w_zero    = r_cnt == '0;
  assign w_dash_nx = (r_state == IDLE) ? w_rom[4] : r_pat[4];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer && w_legal) w_next = (sym.sym_code == 6'd0) ? WGAP : MARK;
      MARK:    if (w_zero) w_next = (r_len == 3'd1) ? CGAP : ESPACE;
      ESPACE:  if (w_zero) w_next = MARK;
      default: if (w_zero) w_next = IDLE;
    endcase
    w_load = (w_next == MARK) ? (w_dash_nx ? L_DASH : L_DOT) :
             (w_next == CGAP) ? L_CGAP : (w_next == WGAP) ? L_WGAP : L_DOT;
  end

  // The counter reloads on every state change, so it never has to wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pat   <= '0;
      r_len   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? w_load : (w_zero ? r_cnt : r_cnt - 1'b1);
      r_done  <= (r_state == CGAP || r_state == WGAP) && w_next == IDLE;
      r_err   <= w_xfer && !w_legal;
      if (w_xfer) {r_len, r_pat} <= w_rom;
      else if (r_state == MARK && w_zero) begin
        r_pat <= {r_pat[3:0], 1'b0};
        r_len <= r_len - 3'd1;
      end
    end
  end

  assign sym.sym_ready  = !rst && r_state == IDLE;
  assign o_busy         = !rst && r_state != IDLE;
  assign o_key_out      = !rst && r_state == MARK;
  assign o_elem_is_dash = o_key_out && r_pat[4];
  assign o_done         = !rst && r_done;
  assign o_err          = !rst && r_err;
endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: random symbol stream checked cycle by cycle against a Morse-string timing model
module tb_morse_keyer;
  localparam int U = 4, DU = 3, CG = 3, WG = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_out, elem_is_dash, busy, done, err;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  morse_keyer_if sym();

  morse_keyer #(.UNIT_CYCLES(U), .DASH_UNITS(DU), .CHAR_GAP_UNITS(CG), .WORD_GAP_UNITS(WG)) dut (
    .clk(clk), .rst(rst), .sym(sym),
    .o_key_out(key_out), .o_elem_is_dash(elem_is_dash), .o_busy(busy), .o_done(done), .o_err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string morse(input int c);
    string t[37] = '{"", ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                     ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...",
                     "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                     "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                     "---..", "----."};
    return t[c];
  endfunction

  // Expected {key_out, elem_is_dash} for every cycle from T1 until the symbol ends
  task automatic build(input int c);
    string p;
    exp_q.delete();
    if (c == 0) begin
      repeat (WG * U) exp_q.push_back(2'b00);
      return;
    end
    p = morse(c);
    for (int i = 0; i < p.len(); i++) begin
      bit d = (p[i] == "-");
      repeat (d ? DU * U : U) exp_q.push_back({1'b1, d});
      if (i < p.len() - 1) repeat (U) exp_q.push_back(2'b00);
    end
    repeat (CG * U) exp_q.push_back(2'b00);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key"}, key_out, 0);
    check({tag, "_dash"}, elem_is_dash, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rdy"}, sym.sym_ready, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after
  task automatic send(input int c);
    sym.sym_valid = 1'b1;
    sym.sym_code  = c[5:0];
    check("rdy_t0", sym.sym_ready, 1);
    @(posedge clk);
    #1;
    sym.sym_code  = 6'($urandom);
    sym.sym_valid = (c > 36) ? 1'b0 : 1'($urandom);
    @(negedge clk);
    if (c > 36) begin
      check("err_t1", err, 1);
      check("bad_rdy", sym.sym_ready, 1);
      check("bad_key", key_out, 0);
      check("bad_busy", busy, 0);
      check("bad_done", done, 0);
      return;
    end
    check("err_t1", err, 0);
    build(c);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      check("key", key_out, exp_q[i][1]);
      check("dash", elem_is_dash, exp_q[i][0]);
      check("busy", busy, 1);
      check("rdy_busy", sym.sym_ready, 0);
      check("done_early", done, 0);
    end
    @(negedge clk);
    check("done", done, 1);
    check("rdy_end", sym.sym_ready, 1);
    check("key_end", key_out, 0);
    check("busy_end", busy, 0);
    check("err_end", err, 0);
  endtask

  task automatic idle(input int k);
    sym.sym_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle_rdy", sym.sym_ready, 1);
      check("idle_done", done, 0);
      check("idle_key", key_out, 0);
    end
  endtask

  task automatic abort(input int c, input int at);
    sym.sym_valid = 1'b1;
    sym.sym_code  = c[5:0];
    @(posedge clk);
    #1;
    sym.sym_valid = 1'b0;
    build(c);
    for (int i = 0; i < at - 1; i++) begin
      @(negedge clk);
      check("ab_key", key_out, exp_q[i][1]);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("ab_rst");
    @(negedge clk);
    check_all_zero("ab_rst2");
    rst = 1'b0;
    @(negedge clk);
    check("ab_rdy", sym.sym_ready, 1);
    check("ab_done", done, 0);
    check("ab_busy", busy, 0);
    check("ab_key2", key_out, 0);
  endtask

  initial begin
    sym.sym_valid = 1'b0;
    sym.sym_code  = 6'd0;
    @(negedge clk);
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_post_rst", sym.sym_ready, 1);
    check("busy_post_rst", busy, 0);
    send(5);
    send(17);
    send(27);
    send(0);
    idle(2);
    send(40);
    send(1);
    idle(1);
    abort(14, 6);
    for (int n = 0; n < 120; n++) begin
      int c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(37, 63)) : int'($urandom_range(0, 36));
      send(c);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    abort(int'($urandom_range(1, 36)), 3);
    send(63);
    send(36);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
